// File: rtl/goodness_calc.sv
// Goodness calculator: streams NUM_NEURONS signed Q16.16 activations from a
// one-cycle-latency buffer, squares each one, and accumulates the sum of
// squares with saturation at the largest positive DATA_WIDTH value. The
// held result is compared against THETA.
module goodness_calc #(
  parameter int                            NUM_NEURONS = 256,
  parameter int                            DATA_WIDTH  = 32,
  parameter int                            FRAC_BITS   = 16,
  parameter logic signed [DATA_WIDTH-1:0]  THETA       = 32'sh00030000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 act_en,
  output logic [$clog2(NUM_NEURONS)-1:0]       act_addr,
  input  logic signed [DATA_WIDTH-1:0]         act_rdata,
  output logic signed [DATA_WIDTH-1:0]         goodness_out,
  output logic                                 above_theta,
  output logic                                 overflow
);

  localparam int              AW        = $clog2(NUM_NEURONS);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(NUM_NEURONS - 1);
  localparam logic [63:0]     SAT_MAX   = (64'd1 << (DATA_WIDTH - 1)) - 64'd1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                    r_state;
  logic [AW-1:0]                 r_addr;
  logic                          r_vld_p1;
  logic [63:0]                   r_acc;
  logic                          r_ovf;
  logic signed [DATA_WIDTH-1:0]  r_good;
  logic                          r_above;
  logic                          r_ovf_out;

  logic signed [63:0]            w_sq_p1;
  logic [63:0]                   w_sum_p1;
  logic                          w_sat_p1;
  logic [63:0]                   w_acc_next;
  logic [63:0]                   w_acc_fin;
  logic signed [DATA_WIDTH-1:0]  w_good_fin;
  logic                          w_accept;

  // Q16.16 square: full signed 64-bit product, rescaled by FRAC_BITS.
  function automatic logic signed [63:0] square_q(input logic signed [DATA_WIDTH-1:0] a);
    logic signed [63:0] ext;
    ext = 64'(a);
    return (ext * ext) >>> FRAC_BITS;
  endfunction

  // Clamp the running sum to the largest positive DATA_WIDTH value.
  function automatic logic [63:0] sat_acc(input logic [63:0] sum);
    return (sum > SAT_MAX) ? SAT_MAX : sum;
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;

  // Square the returned activation and form the saturated next accumulator.
  always_comb begin
    w_sq_p1    = square_q(act_rdata);
    w_sum_p1   = r_acc + $unsigned(w_sq_p1);
    w_sat_p1   = (w_sum_p1 > SAT_MAX);
    w_acc_next = sat_acc(w_sum_p1);
    w_acc_fin  = r_vld_p1 ? w_acc_next : r_acc;
    w_good_fin = w_acc_fin[DATA_WIDTH-1:0];
  end

  // Pass sequencing: issue every address once, drain the last read, then report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_addr  <= '0;
          end
        end
        S_RUN: begin
          if (r_addr == LAST_ADDR) r_state <= S_DRAIN;
          else                     r_addr  <= r_addr + AW'(1);
        end
        S_DRAIN: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after each issued address; accumulate it then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_vld_p1 <= (r_state == S_RUN);
      if (w_accept) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_vld_p1) begin
        r_acc <= w_acc_next;
        r_ovf <= r_ovf | w_sat_p1;
      end
    end
  end

  // Result registers: cleared on an accepted start, loaded as the final sample lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good    <= '0;
      r_above   <= 1'b0;
      r_ovf_out <= 1'b0;
    end else if (w_accept) begin
      r_good    <= '0;
      r_above   <= 1'b0;
      r_ovf_out <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_good    <= w_good_fin;
      r_above   <= (w_good_fin > THETA);
      r_ovf_out <= r_ovf | (r_vld_p1 & w_sat_p1);
    end
  end

  assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign act_en       = (r_state == S_RUN);
  assign act_addr     = r_addr;
  assign goodness_out = r_good;
  assign above_theta  = r_above;
  assign overflow     = r_ovf_out;

endmodule

// File: tb/tb_goodness_calc.sv
// Directed bench for goodness_calc with NUM_NEURONS=4 and a one-cycle-latency
// activation buffer model. Inputs change and outputs are sampled on negedge.
module tb_goodness_calc;

  localparam int N = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               busy;
  logic               done;
  logic               act_en;
  logic [1:0]         act_addr;
  logic [31:0]        act_rdata;
  logic [31:0]        goodness_out;
  logic               above_theta;
  logic               overflow;

  logic [31:0]        mem [N];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0][31:0] acts;
    logic [31:0]      g;
    logic             th;
    logic             ov;
  } vec_t;

  vec_t tbl [10];

  goodness_calc #(
    .NUM_NEURONS(N),
    .DATA_WIDTH (32),
    .FRAC_BITS  (16),
    .THETA      (32'sh00030000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .act_en      (act_en),
    .act_addr    (act_addr),
    .act_rdata   (act_rdata),
    .goodness_out(goodness_out),
    .above_theta (above_theta),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activation buffer: data for an address appears the cycle after act_en.
  always @(posedge clk) begin
    if (act_en) act_rdata <= mem[act_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"},     {31'd0, busy},        32'd0);
    chk({tag, " done"},     {31'd0, done},        32'd0);
    chk({tag, " act_en"},   {31'd0, act_en},      32'd0);
    chk({tag, " act_addr"}, {30'd0, act_addr},    32'd0);
    chk({tag, " goodness"}, goodness_out,         32'd0);
    chk({tag, " above"},    {31'd0, above_theta}, 32'd0);
    chk({tag, " ovf"},      {31'd0, overflow},    32'd0);
  endtask

  // One pass from the current negedge (DUT idle). inj>0 pulses start in that RUN cycle.
  task automatic run_pass(input string tag, input logic [3:0][31:0] acts,
                          input logic [31:0] eg, input logic eth, input logic eov,
                          input int inj);
    int  cyc;
    bit  got;
    bit  seq_ok;
    bit  busy_ok;
    logic exp_en;
    for (int i = 0; i < N; i++) mem[i] = acts[i];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    cyc     = 1;
    got     = 1'b0;
    seq_ok  = 1'b1;
    busy_ok = 1'b1;
    while (cyc <= 20) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      exp_en = (cyc <= N);
      if (act_en !== exp_en) seq_ok = 1'b0;
      if (exp_en && (act_addr !== 2'(cyc - 1))) seq_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = (inj == cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " done seen"},     {31'd0, got},         32'd1);
    chk({tag, " done cycle"},    cyc,                  32'd6);
    chk({tag, " addr seq"},      {31'd0, seq_ok},      32'd1);
    chk({tag, " busy in pass"},  {31'd0, busy_ok},     32'd1);
    chk({tag, " busy at done"},  {31'd0, busy},        32'd0);
    chk({tag, " goodness"},      goodness_out,         eg);
    chk({tag, " above_theta"},   {31'd0, above_theta}, {31'd0, eth});
    chk({tag, " overflow"},      {31'd0, overflow},    {31'd0, eov});
    @(negedge clk);
    chk({tag, " done one cycle"}, {31'd0, done},       32'd0);
    chk({tag, " result held"},   goodness_out,         eg);
  endtask

  initial begin
    int cnt;

    tbl[0] = '{acts: {32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000}, g: 32'h00040000, th: 1'b1, ov: 1'b0};
    tbl[1] = '{acts: {32'h00000000, 32'h00010000, 32'h00010000, 32'h00010000}, g: 32'h00030000, th: 1'b0, ov: 1'b0};
    tbl[2] = '{acts: {32'hFFFE0000, 32'hFFFE0000, 32'hFFFE0000, 32'hFFFE0000}, g: 32'h00100000, th: 1'b1, ov: 1'b0};
    tbl[3] = '{acts: {32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000}, g: 32'h00010000, th: 1'b0, ov: 1'b0};
    tbl[4] = '{acts: {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, g: 32'h7FFFFFFF, th: 1'b1, ov: 1'b1};
    tbl[5] = '{acts: {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000}, g: 32'h00000000, th: 1'b0, ov: 1'b0};
    // 2.0, -1.0, 1.5, 0 -> 4 + 1 + 2.25 = 7.25
    tbl[6] = '{acts: {32'h00000000, 32'h00018000, 32'hFFFF0000, 32'h00020000}, g: 32'h00074000, th: 1'b1, ov: 1'b0};
    // Single most-negative value: 2^62 >> 16 = 2^46, saturates.
    tbl[7] = '{acts: {32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000}, g: 32'h7FFFFFFF, th: 1'b1, ov: 1'b1};
    // 1 LSB squared truncates to 0: total exactly THETA.
    tbl[8] = '{acts: {32'h00000001, 32'h00010000, 32'h00010000, 32'h00010000}, g: 32'h00030000, th: 1'b0, ov: 1'b0};
    // 0x100 squared gives 1 LSB: one above THETA.
    tbl[9] = '{acts: {32'h00000100, 32'h00010000, 32'h00010000, 32'h00010000}, g: 32'h00030001, th: 1'b1, ov: 1'b0};

    rst_n     = 1'b0;
    start     = 1'b0;
    act_rdata = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Back-to-back passes from the table; the first start lands on the first edge after release.
    for (int v = 0; v < 10; v++)
      run_pass($sformatf("vec%0d", v), tbl[v].acts, tbl[v].g, tbl[v].th, tbl[v].ov, 0);

    // start pulsed during RUN: single pass, nothing queued afterwards.
    run_pass("start_in_run", tbl[0].acts, tbl[0].g, tbl[0].th, tbl[0].ov, 2);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("start_in_run no extra pass", cnt, 32'd0);

    // start held through the DONE cycle: ignored there, accepted in the following IDLE.
    for (int i = 0; i < N; i++) mem[i] = tbl[2].acts[i];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_start done", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    chk("done_start ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_start accepted", {31'd0, busy}, 32'd1);
    chk("idle_start cleared", goodness_out, 32'd0);
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("idle_start done cycle", cnt, 32'd5);
    chk("idle_start goodness", goodness_out, 32'h00100000);
    @(negedge clk);

    // Reset during cycle 3 of a pass aborts it.
    for (int i = 0; i < N; i++) mem[i] = tbl[0].acts[i];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("mid_reset");
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("mid_reset no done", cnt, 32'd0);
    run_pass("after_reset", tbl[6].acts, tbl[6].g, tbl[6].th, tbl[6].ov, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
